// File: rtl/libeth.sv
// Shared definitions for the Ethernet RX DMA blocks: FSM encoding and
// command-word field layout.
package libeth;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } rx_state_e;

    localparam int CMD_W             = 64;
    localparam int LEN_LSB           = 0;
    localparam int LEN_W             = 16;
    localparam int QSEL_LSB_DEFAULT  = 48;
    localparam int NWORDS_W          = 12;
    localparam logic [15:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/eth_dma_rx_mq.sv
// RX DMA frame steering: accepts a command plus data words from the MAC and
// forwards them to one of NQ destination queues, or drops the frame.
module eth_dma_rx_mq
    import libeth::*;
#(
    parameter int NQ       = 4,
    parameter int DW       = 32,
    parameter int QSEL_LSB = QSEL_LSB_DEFAULT,
    parameter int DROP_EN  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  in_cmd_bits,
    input  logic              in_cmd_val,
    output logic              in_cmd_rdy,
    input  logic [DW-1:0]     in_data_bits,
    input  logic              in_data_val,
    output logic              in_data_rdy,
    output logic [CMD_W-1:0]  out_cmd_bits,
    output logic [NQ-1:0]     out_cmd_val,
    input  logic [NQ-1:0]     out_cmd_rdy,
    output logic [DW-1:0]     out_data_bits,
    output logic [NQ-1:0]     out_data_val,
    input  logic [NQ-1:0]     out_data_rdy,
    output logic [15:0]       drop_count,
    output logic              busy
);

    localparam int QW       = $clog2(NQ);
    localparam int BPW_LOG2 = $clog2(DW / 8);
    localparam logic [LEN_W:0] LEN_RND = (LEN_W + 1)'((DW / 8) - 1);

    rx_state_e              state_q, state_d;
    logic [CMD_W-1:0]       cmd_q, cmd_d;
    logic [QW-1:0]          q_q, q_d;
    logic [NWORDS_W-1:0]    cnt_q, cnt_d;
    logic [15:0]            drop_q, drop_d;

    logic [QW-1:0]          in_q;
    logic [LEN_W:0]         len_rnd;
    logic [NWORDS_W-1:0]    nwords_in;
    logic [NQ-1:0]          q_oh;
    logic                   drop_now;
    logic                   data_hs;

    // Round the byte length up to whole words before shifting down.
    assign in_q      = in_cmd_bits[QSEL_LSB +: QW];
    assign len_rnd   = {1'b0, in_cmd_bits[LEN_LSB +: LEN_W]} + LEN_RND;
    assign nwords_in = len_rnd[BPW_LOG2 +: NWORDS_W];
    assign q_oh      = NQ'(1) << q_q;
    assign drop_now  = (DROP_EN != 0) && !out_cmd_rdy[in_q];
    assign data_hs   = in_data_val && ((state_q == ST_DROP) ||
                                       (state_q == ST_DATA && out_data_rdy[q_q]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (in_cmd_val) begin
                    cmd_d = in_cmd_bits;
                    q_d   = in_q;
                    cnt_d = nwords_in;
                    if (drop_now) begin
                        state_d = (nwords_in == '0) ? ST_IDLE : ST_DROP;
                        if (drop_q != DROP_MAX) begin
                            drop_d = drop_q + 16'd1;
                        end
                    end else begin
                        state_d = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                if (out_cmd_rdy[q_q]) begin
                    state_d = (cnt_q == '0) ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA, ST_DROP: begin
                if (data_hs) begin
                    cnt_d = cnt_q - NWORDS_W'(1);
                    if (cnt_q == NWORDS_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are gated by reset so nothing is offered while it is held.
    always_comb begin
        in_cmd_rdy   = 1'b0;
        in_data_rdy  = 1'b0;
        out_cmd_val  = '0;
        out_data_val = '0;
        busy         = 1'b0;
        if (reset) begin
            busy = (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: in_cmd_rdy = 1'b1;
                ST_CMD:  out_cmd_val = q_oh;
                ST_DATA: begin
                    out_data_val = in_data_val ? q_oh : '0;
                    in_data_rdy  = out_data_rdy[q_q];
                end
                ST_DROP: in_data_rdy = 1'b1;
                default: ;
            endcase
        end
    end

    assign out_cmd_bits  = cmd_q;
    assign out_data_bits = in_data_bits;
    assign drop_count    = drop_q;

endmodule
